// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC conversion sequencer.
package adc_pkg;

  // Width of the SAR ADC result bus.
  localparam int unsigned ADC_DW = 5;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_CONV  = 3'd3,
    S_PUB   = 3'd4
  } state_e;

endpackage

// File: rtl/adc_sample_ctrl_if.sv
// Valid/ready port carrying the averaged ADC result to its consumer.
interface adc_sample_ctrl_if;
  import adc_pkg::*;

  logic [ADC_DW-1:0] avgOut;
  logic              avgValid;
  logic              avgReady;

  // Producer side (the sequencer).
  modport master (
    output avgOut,
    output avgValid,
    input  avgReady
  );

  // Consumer side.
  modport slave (
    input  avgOut,
    input  avgValid,
    output avgReady
  );

endinterface

// File: rtl/adc_avg_accum.sv
// Accumulates ADC samples and divides the sum by 2^LOG2_AVG with a shift.
module adc_avg_accum
  import adc_pkg::*;
#(
  parameter int unsigned LOG2_AVG = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic              publish,
  input  logic [ADC_DW-1:0] data,
  output logic              last,
  output logic [ADC_DW-1:0] avg
);

  // Sum of 2^LOG2_AVG samples of ADC_DW bits always fits in AccW bits.
  localparam int unsigned AccW = ADC_DW + LOG2_AVG;
  localparam int unsigned CntW = LOG2_AVG + 1;

  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next accumulator and sample count; a clear or publish empties both.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear || publish) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add) begin
      acc_d = acc_q + AccW'(data);
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Accumulator and sample count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // The sample being added now completes the set.
  assign last = (cnt_q == CntW'((1 << LOG2_AVG) - 1));
  assign avg  = ADC_DW'(acc_q >> LOG2_AVG);

endmodule

// File: rtl/adc_sample_ctrl.sv
// Periodic conversion sequencer for the 5-bit SAR ADC with averaging,
// timeout detection and overrun flagging on the result port.
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned PERIOD   = 64,
  parameter int unsigned LOG2_AVG = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clrErr,
  input  logic              nEndCnv,
  input  logic [ADC_DW-1:0] adcData,
  output logic              nStartCnv,
  adc_sample_ctrl_if.master avgIf,
  output logic              busy,
  output logic              overrun,
  output logic              timeoutErr
);

  localparam int unsigned PerW = 16;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_e state_q, state_d, resume_st;

  logic [PerW-1:0]   per_q;
  logic [TmoW-1:0]   tmo_q;
  logic              tmo_hit;
  logic              acc_clear, acc_add, acc_publish, acc_last, abort;
  logic [ADC_DW-1:0] acc_avg;

  logic              nstart_q;
  logic [ADC_DW-1:0] avg_q, avg_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              tmo_err_q, tmo_err_d;

  // Where every decision point goes next: keep running or park.
  assign resume_st = enable ? S_WAIT : S_IDLE;

  // TIMEOUT cycles have now been spent in S_START plus S_CONV.
  assign tmo_hit = ((state_q == S_START) || (state_q == S_CONV)) &&
                   (tmo_q == TmoW'(TIMEOUT - 1));

  // Next-state logic and accumulator strobes.
  always_comb begin
    state_d     = state_q;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;
    acc_publish = 1'b0;
    abort       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        acc_clear = 1'b1;
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (per_q == '0) state_d = enable ? S_START : S_IDLE;
      end
      S_START: begin
        if (tmo_hit) begin
          abort     = 1'b1;
          acc_clear = 1'b1;
          state_d   = resume_st;
        end else if (nEndCnv) begin
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // A result landing in the final timeout cycle is still taken.
        if (!nEndCnv) begin
          acc_add = 1'b1;
          state_d = acc_last ? S_PUB : resume_st;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          acc_clear = 1'b1;
          state_d   = resume_st;
        end
      end
      S_PUB: begin
        acc_publish = 1'b1;
        state_d     = resume_st;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Period counter: loads on entry to S_WAIT and counts down to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      per_q <= '0;
    end else if ((state_d == S_WAIT) && (state_q != S_WAIT)) begin
      per_q <= PerW'(PERIOD - 1);
    end else if ((state_q == S_WAIT) && (per_q != '0)) begin
      per_q <= per_q - PerW'(1);
    end
  end

  // Timeout counter: zeroed on entry to S_START, runs through S_CONV.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if ((state_d == S_START) && (state_q != S_START)) begin
      tmo_q <= '0;
    end else if ((state_q == S_START) || (state_q == S_CONV)) begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end

  // Registered start request so the ADC sees a glitch-free level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) nstart_q <= 1'b1;
    else        nstart_q <= (state_d != S_START);
  end

  adc_avg_accum #(
    .LOG2_AVG (LOG2_AVG)
  ) u_accum (
    .clock   (clock),
    .reset   (reset),
    .clear   (acc_clear),
    .add     (acc_add),
    .publish (acc_publish),
    .data    (adcData),
    .last    (acc_last),
    .avg     (acc_avg)
  );

  // Result port handshake and sticky error flags; a new set wins over clrErr.
  always_comb begin
    avg_d     = avg_q;
    valid_d   = valid_q;
    overrun_d = overrun_q & ~clrErr;
    tmo_err_d = tmo_err_q & ~clrErr;
    if (valid_q && avgIf.avgReady) valid_d = 1'b0;
    if (acc_publish) begin
      avg_d   = acc_avg;
      valid_d = 1'b1;
      if (valid_q && !avgIf.avgReady) overrun_d = 1'b1;
    end
    if (abort) tmo_err_d = 1'b1;
  end

  // Output and flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      avg_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      avg_q     <= avg_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign nStartCnv      = nstart_q;
  assign avgIf.avgOut   = avg_q;
  assign avgIf.avgValid = valid_q;
  assign busy           = (state_q != S_IDLE);
  assign overrun        = overrun_q;
  assign timeoutErr     = tmo_err_q;

endmodule
